// File: rtl/uart_rx_oversampled.sv
// rtl/uart_rx_oversampled.sv - 16x oversampled UART receiver with glitch rejection, optional parity and framing check
`timescale 1ns/1ps

module uart_rx_oversampled #(
    parameter int DBIT       = 8,   // data bits per frame, 5..8
    parameter int SB_TICK    = 16,  // ticks in stop state: 16/24/32 = 1/1.5/2 stop bits
    parameter int PARITY_EN  = 0,   // 1 = parity bit follows data
    parameter int PARITY_ODD = 0    // 0 = even, 1 = odd
) (
    input  logic            clk,           // rising-edge clock
    input  logic            reset,         // synchronous, active-high
    input  logic            rx,            // asynchronous serial line, idle high
    input  logic            s_tick,        // 16x oversampling enable
    output logic [DBIT-1:0] dout,          // last received word
    output logic            rx_done_tick,  // one-cycle frame-complete pulse
    output logic            frame_err,     // stop bit sampled low on last frame
    output logic            parity_err,    // parity mismatch on last frame
    output logic            busy           // receiver not idle
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [4:0] SB_LAST  = 5'(SB_TICK - 1);
    localparam logic [2:0] N_LAST   = 3'(DBIT - 1);
    localparam logic       PAR_ON   = (PARITY_EN != 0);
    localparam logic       PAR_INIT = (PARITY_ODD != 0);

    logic            rx_meta, rx_s;
    state_t          state_q, state_d;
    logic [4:0]      s_q, s_d;
    logic [2:0]      n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            acc_q, acc_d;
    logic            mism_q, mism_d;
    logic            armed_q, armed_d;
    logic [DBIT-1:0] dout_d;
    logic            done_d, frame_err_d, parity_err_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta      <= 1'b1;
            rx_s         <= 1'b1;
            state_q      <= IDLE;
            s_q          <= '0;
            n_q          <= '0;
            b_q          <= '0;
            acc_q        <= 1'b0;
            mism_q       <= 1'b0;
            armed_q      <= 1'b0;
            dout         <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
            parity_err   <= 1'b0;
        end else begin
            rx_meta      <= rx;
            rx_s         <= rx_meta;
            state_q      <= state_d;
            s_q          <= s_d;
            n_q          <= n_d;
            b_q          <= b_d;
            acc_q        <= acc_d;
            mism_q       <= mism_d;
            armed_q      <= armed_d;
            dout         <= dout_d;
            rx_done_tick <= done_d;
            frame_err    <= frame_err_d;
            parity_err   <= parity_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        s_d          = s_q;
        n_d          = n_q;
        b_d          = b_q;
        acc_d        = acc_q;
        mism_d       = mism_q;
        armed_d      = armed_q;
        dout_d       = dout;
        done_d       = 1'b0;
        frame_err_d  = frame_err;
        parity_err_d = parity_err;

        case (state_q)
            IDLE: begin
                // A start edge only counts once the line has been seen high,
                // so a held-low break does not retrigger frames.
                if (armed_q && !rx_s) begin
                    state_d = START;
                    s_d     = '0;
                    armed_d = 1'b0;
                end else if (rx_s) begin
                    armed_d = 1'b1;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == 5'd7) begin
                        if (!rx_s) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                            acc_d   = PAR_INIT;
                            mism_d  = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == 5'd15) begin
                        s_d   = '0;
                        b_d   = {rx_s, b_q[DBIT-1:1]};
                        acc_d = acc_q ^ rx_s;
                        if (n_q == N_LAST) begin
                            state_d = PAR_ON ? PARITY : STOP;
                        end else begin
                            n_d = n_q + 3'd1;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            PARITY: begin
                if (s_tick) begin
                    if (s_q == 5'd15) begin
                        s_d     = '0;
                        mism_d  = acc_q ^ rx_s;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_q == SB_LAST) begin
                        dout_d       = b_q;
                        frame_err_d  = ~rx_s;
                        parity_err_d = PAR_ON & mism_q;
                        done_d       = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb/tb_uart_rx_oversampled.sv - randomized scoreboard bench for uart_rx_oversampled (8N1 and 8E1 instances)
`timescale 1ns/1ps

module tb_uart_rx_oversampled;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       rx0 = 1'b1, rx1 = 1'b1;
    logic       s_tick = 1'b0;
    logic [7:0] dout0, dout1;
    logic       done0, done1, fe0, fe1, pe0, pe1, busy0, busy1;

    uart_rx_oversampled #(.DBIT(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)) u_dut0 (
        .clk(clk), .reset(reset), .rx(rx0), .s_tick(s_tick),
        .dout(dout0), .rx_done_tick(done0), .frame_err(fe0), .parity_err(pe0), .busy(busy0)
    );

    uart_rx_oversampled #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
        .clk(clk), .reset(reset), .rx(rx1), .s_tick(s_tick),
        .dout(dout1), .rx_done_tick(done1), .frame_err(fe1), .parity_err(pe1), .busy(busy1)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   total = 0;
    int   bad = 0;
    int   tick_div = 1;
    int   tick_cnt = 0;
    logic pb0 = 1'b0, pb1 = 1'b0;

    // Tick generator: one s_tick pulse every tick_div cycles, updated just after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tick_cnt >= tick_div - 1) begin
                tick_cnt = 0;
                s_tick   = 1'b1;
            end else begin
                tick_cnt = tick_cnt + 1;
                s_tick   = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total = total + 1;
        if (act !== want) begin
            bad = bad + 1;
            $display("FAIL %s: got=%0h want=%0h", name, act, want);
        end
    endtask

    // Monitor: every completion pulse is matched against the oldest expected frame.
    always @(negedge clk) begin
        if (done0) begin
            if (q0.size() == 0) begin
                total = total + 1;
                bad   = bad + 1;
                $display("FAIL spurious_done0: got=%0h want=no_frame", dout0);
            end else begin
                e0 = q0.pop_front();
                chk("dout0", 32'(dout0), 32'(e0.d));
                chk("frame_err0", 32'(fe0), 32'(e0.fe));
                chk("parity_err0", 32'(pe0), 32'(e0.pe));
                chk("busy_drop0", 32'({pb0, busy0}), 32'(2'b10));
            end
        end
        if (done1) begin
            if (q1.size() == 0) begin
                total = total + 1;
                bad   = bad + 1;
                $display("FAIL spurious_done1: got=%0h want=no_frame", dout1);
            end else begin
                e1 = q1.pop_front();
                chk("dout1", 32'(dout1), 32'(e1.d));
                chk("frame_err1", 32'(fe1), 32'(e1.fe));
                chk("parity_err1", 32'(pe1), 32'(e1.pe));
                chk("busy_drop1", 32'({pb1, busy1}), 32'(2'b10));
            end
        end
        pb0 = busy0;
        pb1 = busy1;
    end

    task automatic tick_wait(input int n);
        int k = 0;
        while (k < n) begin
            @(posedge clk);
            if (s_tick) k = k + 1;
        end
        #2;
    endtask

    task automatic set_rx(input int which, input logic v);
        if (which == 0) rx0 = v;
        else            rx1 = v;
    endtask

    task automatic drive_bit(input int which, input logic v, input int ticks);
        set_rx(which, v);
        tick_wait(ticks);
    endtask

    // Reference model: the frame's outcome follows directly from the bits put on the line.
    task automatic send_frame(input int which, input logic [7:0] d, input logic pbit,
                              input logic stop, input int low_ext);
        exp_t e;
        e.d  = d;
        e.fe = ~stop;
        e.pe = (which == 1) ? (pbit != (^d)) : 1'b0;
        if (which == 0) q0.push_back(e);
        else            q1.push_back(e);
        drive_bit(which, 1'b0, 16);
        for (int i = 0; i < 8; i++) drive_bit(which, d[i], 16);
        if (which == 1) drive_bit(which, pbit, 16);
        drive_bit(which, stop, 16);
        if (low_ext > 0) drive_bit(which, 1'b0, low_ext);
        set_rx(which, 1'b1);
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((q0.size() != 0 || q1.size() != 0) && k < 20000) begin
            @(negedge clk);
            k = k + 1;
        end
        total = total + 1;
        if (q0.size() != 0 || q1.size() != 0) begin
            bad = bad + 1;
            $display("FAIL drain_%s: got=%0d_pending want=0", name, q0.size() + q1.size());
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({"rst_dout0_", tag}, 32'(dout0), 32'h0);
        chk({"rst_done0_", tag}, 32'(done0), 32'h0);
        chk({"rst_fe0_", tag}, 32'(fe0), 32'h0);
        chk({"rst_busy0_", tag}, 32'(busy0), 32'h0);
        chk({"rst_dout1_", tag}, 32'(dout1), 32'h0);
        chk({"rst_pe1_", tag}, 32'(pe1), 32'h0);
        chk({"rst_busy1_", tag}, 32'(busy1), 32'h0);
    endtask

    initial begin
        logic [7:0] d;
        logic       st;
        int         ext;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("init");
        @(posedge clk);
        #2;
        reset = 1'b0;
        tick_wait(20);

        // 8N1 basic frame
        send_frame(0, 8'h55, 1'b0, 1'b1, 0);
        drain("basic");

        // start glitch: 4 ticks low
        drive_bit(0, 1'b0, 4);
        drive_bit(0, 1'b1, 40);
        chk("glitch_dout", 32'(dout0), 32'h55);
        chk("glitch_busy", 32'(busy0), 32'h0);

        // framing error with held-low line, then recovery
        send_frame(0, 8'h3C, 1'b0, 1'b0, 48);
        chk("break_dout", 32'(dout0), 32'h3C);
        chk("break_fe", 32'(fe0), 32'h1);
        tick_wait(20);
        send_frame(0, 8'h81, 1'b0, 1'b1, 0);
        drain("break");

        // even parity, correct then wrong parity bit
        send_frame(1, 8'hA3, 1'b0, 1'b1, 0);
        send_frame(1, 8'hA3, 1'b1, 1'b1, 0);
        drain("parity");

        // reset in the middle of data bit 4
        drive_bit(0, 1'b0, 16);
        for (int i = 0; i < 4; i++) drive_bit(0, i[0], 16);
        drive_bit(0, 1'b1, 8);
        reset = 1'b1;
        rx0   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("mid");
        @(posedge clk);
        #2;
        reset = 1'b0;
        tick_wait(20);
        send_frame(0, 8'hF0, 1'b0, 1'b1, 0);
        drain("after_reset");

        // randomized frames on both receivers
        for (int k = 0; k < 12; k++) begin
            tick_div = $urandom_range(1, 4);
            d   = 8'($urandom);
            st  = ($urandom_range(0, 3) != 0);
            ext = st ? 0 : $urandom_range(0, 48);
            send_frame(k % 2, d, 1'($urandom), st, ext);
            tick_wait(st ? $urandom_range(0, 8) : 16);
        end
        drain("random");

        // sparse ticks, back-to-back frames
        tick_div = 40;
        tick_wait(4);
        send_frame(0, 8'h00, 1'b0, 1'b1, 0);
        send_frame(0, 8'hFF, 1'b0, 1'b1, 0);
        drain("sparse");
        chk("sparse_idle_busy", 32'(busy0), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
